// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the fetch-side PC sequencer of the RISC-V core:
//   - branch type encodings driven by the execute stage
//   - sequencer state encoding
//   - instruction size in bytes, used for sequential PC advance
// No ports (package).
// ---------------------------------------------------------------------------
package rv_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_TRAP   = 2'd3
    } seq_state_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
// Combinational control-flow resolution: decides whether the instruction
// from execute is taken and computes its target address.
// Ports:
//   br_type    in   3     branch code (see rv_pkg BR_*)
//   zero       in   1     ALU zero flag
//   result0    in   1     ALU result bit 0 (less-than outcome)
//   pc         in   XLEN  PC of the resolved instruction
//   busa       in   XLEN  rs1 value, base address for jalr
//   imm        in   XLEN  sign-extended immediate
//   taken      out  1     control transfer happens
//   target     out  XLEN  destination address
//   misaligned out  1     target is not 4-byte aligned
// ---------------------------------------------------------------------------
module branch_resolve
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      br_type,
    input  logic            zero,
    input  logic            result0,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] busa,
    input  logic [XLEN-1:0] imm,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_sum;

    // Unlisted codes (including 011) fall through to not-taken.
    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BLT:  taken = result0;
            BR_BGE:  taken = ~result0;
            default: taken = 1'b0;
        endcase
    end

    // jalr is register-relative and drops bit 0 of the sum; everything
    // else is PC-relative. The add simply wraps, carry is discarded.
    always_comb begin
        w_base = (br_type == BR_JALR) ? busa : pc;
        w_sum  = w_base + imm;
        target = w_sum;
        if (br_type == BR_JALR) begin
            target[0] = 1'b0;
        end
        misaligned = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Owns the architectural PC, issues instruction fetches over a valid/ready
// handshake, applies redirects from the execute stage with a one-cycle
// bubble, and traps on misaligned control-flow targets.
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   fetch_valid  out  1      fetch request valid
//   fetch_ready  in   1      instruction memory accepts the request
//   fetch_pc     out  XLEN   fetch address
//   br_valid     in   1      execute presents a resolved control-flow instr
//   br_type      in   3      branch code
//   br_zero      in   1      ALU zero flag
//   br_result0   in   1      ALU result bit 0
//   br_pc        in   XLEN   PC of the resolved instruction
//   br_busa      in   XLEN   rs1 value (jalr base)
//   br_imm       in   XLEN   sign-extended immediate
//   trap_clear   in   1      leave TRAP and restart at RESET_VECTOR
//   redirect     out  1      pulse: taken redirect accepted
//   trap         out  1      misaligned-target trap active
//   trap_addr    out  XLEN   offending target
//   fetch_count  out  CNT_W  number of accepted fetch handshakes
// ---------------------------------------------------------------------------
module pc_sequencer
    import rv_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  fetch_pc,
    input  logic             br_valid,
    input  logic [2:0]       br_type,
    input  logic             br_zero,
    input  logic             br_result0,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_busa,
    input  logic [XLEN-1:0]  br_imm,
    input  logic             trap_clear,
    output logic             redirect,
    output logic             trap,
    output logic [XLEN-1:0]  trap_addr,
    output logic [CNT_W-1:0] fetch_count
);

    seq_state_e       r_state;
    logic [XLEN-1:0]  r_pc;
    logic             r_fetch_valid;
    logic             r_redirect;
    logic             r_trap;
    logic [XLEN-1:0]  r_trap_addr;
    logic [CNT_W-1:0] r_fetch_count;

    seq_state_e       w_state_nxt;
    logic [XLEN-1:0]  w_pc_nxt;
    logic             w_taken;
    logic [XLEN-1:0]  w_target;
    logic             w_misaligned;
    logic             w_br_live;
    logic             w_jump_ok;
    logic             w_jump_bad;
    logic             w_handshake;

    branch_resolve #(
        .XLEN(XLEN)
    ) u_resolve (
        .br_type    (br_type),
        .zero       (br_zero),
        .result0    (br_result0),
        .pc         (br_pc),
        .busa       (br_busa),
        .imm        (br_imm),
        .taken      (w_taken),
        .target     (w_target),
        .misaligned (w_misaligned)
    );

    // Execute results only matter while the pipeline is running; in BOOT
    // and TRAP they are ignored.
    always_comb begin
        w_br_live   = br_valid && ((r_state == ST_FETCH) || (r_state == ST_BUBBLE));
        w_jump_ok   = w_br_live && w_taken && !w_misaligned;
        w_jump_bad  = w_br_live && w_taken && w_misaligned;
        w_handshake = r_fetch_valid && fetch_ready;
    end

    // Next state and next PC. A redirect wins over sequential advance even
    // when the fetch handshake completes in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH, ST_BUBBLE: begin
                if (w_jump_ok) begin
                    w_state_nxt = ST_BUBBLE;
                    w_pc_nxt    = w_target;
                end else if (w_jump_bad) begin
                    w_state_nxt = ST_TRAP;
                end else begin
                    w_state_nxt = ST_FETCH;
                    if (w_handshake) begin
                        w_pc_nxt = r_pc + XLEN'(INSTR_BYTES);
                    end
                end
            end
            ST_TRAP: begin
                if (trap_clear) begin
                    w_state_nxt = ST_BOOT;
                    w_pc_nxt    = RESET_VECTOR;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_pc_nxt    = RESET_VECTOR;
            end
        endcase
    end

    // All status outputs are registered; fetch_valid is precomputed from
    // the next state so it is high exactly while the state is FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_VECTOR;
            r_fetch_valid <= 1'b0;
            r_redirect    <= 1'b0;
            r_trap        <= 1'b0;
            r_trap_addr   <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fetch_valid <= (w_state_nxt == ST_FETCH);
            r_redirect    <= w_jump_ok;
            if (w_handshake) begin
                r_fetch_count <= r_fetch_count + CNT_W'(1);
            end
            if (w_jump_bad) begin
                r_trap      <= 1'b1;
                r_trap_addr <= w_target;
            end else if ((r_state == ST_TRAP) && trap_clear) begin
                r_trap <= 1'b0;
            end
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign fetch_pc    = r_pc;
    assign redirect    = r_redirect;
    assign trap        = r_trap;
    assign trap_addr   = r_trap_addr;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed, table-driven bench for pc_sequencer: each vector drives one
// cycle of inputs and states the outputs expected after the next edge.
// Hand-written sequences cover asynchronous reset in BUBBLE and TRAP.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             fetch_valid;
    logic             fetch_ready;
    logic [XLEN-1:0]  fetch_pc;
    logic             br_valid;
    logic [2:0]       br_type;
    logic             br_zero;
    logic             br_result0;
    logic [XLEN-1:0]  br_pc;
    logic [XLEN-1:0]  br_busa;
    logic [XLEN-1:0]  br_imm;
    logic             trap_clear;
    logic             redirect;
    logic             trap;
    logic [XLEN-1:0]  trap_addr;
    logic [CNT_W-1:0] fetch_count;

    int checkCount;
    int errorCount;

    typedef struct {
        string       name;
        logic        rdy;
        logic        bv;
        logic [2:0]  bt;
        logic        bz;
        logic        br0;
        logic [31:0] bpc;
        logic [31:0] bbusa;
        logic [31:0] bimm;
        logic        tclr;
        logic        eFv;
        logic [31:0] ePc;
        logic        eRedir;
        logic        eTrap;
        logic [31:0] eTaddr;
        logic [31:0] eCnt;
    } vec_t;

    vec_t vecs[$];

    pc_sequencer #(
        .XLEN         (XLEN),
        .RESET_VECTOR (32'h0000_0000),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_pc    (fetch_pc),
        .br_valid    (br_valid),
        .br_type     (br_type),
        .br_zero     (br_zero),
        .br_result0  (br_result0),
        .br_pc       (br_pc),
        .br_busa     (br_busa),
        .br_imm      (br_imm),
        .trap_clear  (trap_clear),
        .redirect    (redirect),
        .trap        (trap),
        .trap_addr   (trap_addr),
        .fetch_count (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One field comparison, counted and reported on failure.
    task automatic checkField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s %s actual=%h expected=%h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic eFv, input logic [31:0] ePc,
                               input logic eRedir, input logic eTrap,
                               input logic [31:0] eTaddr, input logic [31:0] eCnt);
        checkField(name, "fetch_valid", {31'd0, fetch_valid}, {31'd0, eFv});
        checkField(name, "fetch_pc",    fetch_pc,             ePc);
        checkField(name, "redirect",    {31'd0, redirect},    {31'd0, eRedir});
        checkField(name, "trap",        {31'd0, trap},        {31'd0, eTrap});
        checkField(name, "trap_addr",   trap_addr,            eTaddr);
        checkField(name, "fetch_count", fetch_count,          eCnt);
    endtask

    task automatic applyStimulus(input vec_t v);
        fetch_ready = v.rdy;
        br_valid    = v.bv;
        br_type     = v.bt;
        br_zero     = v.bz;
        br_result0  = v.br0;
        br_pc       = v.bpc;
        br_busa     = v.bbusa;
        br_imm      = v.bimm;
        trap_clear  = v.tclr;
    endtask

    task automatic addVec(input string name, input logic rdy, input logic bv,
                          input logic [2:0] bt, input logic bz, input logic br0,
                          input logic [31:0] bpc, input logic [31:0] bbusa,
                          input logic [31:0] bimm, input logic tclr,
                          input logic eFv, input logic [31:0] ePc, input logic eRedir,
                          input logic eTrap, input logic [31:0] eTaddr,
                          input logic [31:0] eCnt);
        vec_t v;
        v.name = name; v.rdy = rdy; v.bv = bv; v.bt = bt; v.bz = bz; v.br0 = br0;
        v.bpc = bpc; v.bbusa = bbusa; v.bimm = bimm; v.tclr = tclr;
        v.eFv = eFv; v.ePc = ePc; v.eRedir = eRedir; v.eTrap = eTrap;
        v.eTaddr = eTaddr; v.eCnt = eCnt;
        vecs.push_back(v);
    endtask

    task automatic idleInputs();
        vec_t v;
        v.name = "idle"; v.rdy = 1'b0; v.bv = 1'b0; v.bt = 3'b000; v.bz = 1'b0;
        v.br0 = 1'b0; v.bpc = '0; v.bbusa = '0; v.bimm = '0; v.tclr = 1'b0;
        v.eFv = 1'b0; v.ePc = '0; v.eRedir = 1'b0; v.eTrap = 1'b0;
        v.eTaddr = '0; v.eCnt = '0;
        applyStimulus(v);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;

        //     name          rdy bv type   z  r0 br_pc         busa          imm           clr  fv pc            rd tr taddr         cnt
        addVec("boot",        1, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h0,        0, 0, 32'h0,        0);
        addVec("seq4",        1, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h4,        0, 0, 32'h0,        1);
        addVec("seq8",        1, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h8,        0, 0, 32'h0,        2);
        addVec("stall1",      0, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h8,        0, 0, 32'h0,        2);
        addVec("stall2",      0, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h8,        0, 0, 32'h0,        2);
        addVec("stall3",      0, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h8,        0, 0, 32'h0,        2);
        addVec("seq12",       1, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'hC,        0, 0, 32'h0,        3);
        addVec("seq16",       1, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h10,       0, 0, 32'h0,        4);
        addVec("beq_taken",   1, 1, 3'b100,1, 0, 32'h10,       32'h0,        32'h20,       0,   0, 32'h30,       1, 0, 32'h0,        5);
        addVec("bubble_out",  1, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h30,       0, 0, 32'h0,        5);
        addVec("beq_ntaken",  1, 1, 3'b100,0, 0, 32'h10,       32'h0,        32'h20,       0,   1, 32'h34,       0, 0, 32'h0,        6);
        addVec("code011",     0, 1, 3'b011,1, 1, 32'h0,        32'h0,        32'h8,        0,   1, 32'h34,       0, 0, 32'h0,        6);
        addVec("bne_ntaken",  0, 1, 3'b101,1, 0, 32'h0,        32'h0,        32'h8,        0,   1, 32'h34,       0, 0, 32'h0,        6);
        addVec("blt_wrap",    0, 1, 3'b110,0, 1, 32'hFFFFFFF0, 32'h0,        32'h10C,      0,   0, 32'hFC,       1, 0, 32'h0,        6);
        addVec("bge_ntaken",  0, 1, 3'b111,0, 1, 32'h0,        32'h0,        32'h8,        0,   1, 32'hFC,       0, 0, 32'h0,        6);
        addVec("jalr_bit0",   0, 1, 3'b010,0, 0, 32'h0,        32'h101,      32'h4,        0,   0, 32'h104,      1, 0, 32'h0,        6);
        addVec("jal_in_bub",  0, 1, 3'b001,0, 0, 32'h200,      32'h0,        32'h10,       0,   0, 32'h210,      1, 0, 32'h0,        6);
        addVec("after_bub",   1, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h210,      0, 0, 32'h0,        6);
        addVec("seq214",      1, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h214,      0, 0, 32'h0,        7);
        addVec("jal_misal",   0, 1, 3'b001,0, 0, 32'h40,       32'h0,        32'h2,        0,   0, 32'h214,      0, 1, 32'h42,       7);
        addVec("trap_ignore", 1, 1, 3'b100,1, 0, 32'h10,       32'h0,        32'h20,       0,   0, 32'h214,      0, 1, 32'h42,       7);
        addVec("trap_clear",  0, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        1,   0, 32'h0,        0, 0, 32'h42,       7);
        addVec("reboot",      0, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h0,        0, 0, 32'h42,       7);
        addVec("reseq4",      1, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h4,        0, 0, 32'h42,       8);
        addVec("bge_taken",   0, 1, 3'b111,0, 0, 32'h4,        32'h0,        32'h1C,       0,   0, 32'h20,       1, 0, 32'h42,       8);
        addVec("at20_stall",  0, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h20,       0, 0, 32'h42,       8);
        addVec("abandon",     0, 1, 3'b001,0, 0, 32'h20,       32'h0,        32'h60,       0,   0, 32'h80,       1, 0, 32'h42,       8);
        addVec("abandon_bub", 1, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h80,       0, 0, 32'h42,       8);
        addVec("seq84",       1, 0, 3'b000,0, 0, 32'h0,        32'h0,        32'h0,        0,   1, 32'h84,       0, 0, 32'h42,       9);

        // Reset is held across one edge and released between edges.
        rst = 1'b1;
        idleInputs();
        #12;
        rst = 1'b0;
        #1;
        checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name, vecs[i].eFv, vecs[i].ePc, vecs[i].eRedir,
                        vecs[i].eTrap, vecs[i].eTaddr, vecs[i].eCnt);
        end

        // Async reset while in BUBBLE: outputs clear before any clock edge.
        br_valid = 1'b1; br_type = 3'b001; br_pc = 32'h0; br_imm = 32'h40;
        fetch_ready = 1'b0; trap_clear = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("enter_bubble", 1'b0, 32'h40, 1'b1, 1'b0, 32'h42, 32'h9);
        idleInputs();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_in_bubble", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("boot_after_rst", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Async reset while in TRAP.
        br_valid = 1'b1; br_type = 3'b001; br_pc = 32'h0; br_imm = 32'h6;
        fetch_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("enter_trap", 1'b0, 32'h0, 1'b0, 1'b1, 32'h6, 32'h0);
        idleInputs();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_in_trap", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
